// File: rtl/bp_pkg.sv
// bp_pkg: shared counter type, counter encodings and saturating update for the branch predictor
package bp_pkg;

   typedef logic [1:0] bp_ctr_t;

   localparam bp_ctr_t CTR_SNT = 2'b00;
   localparam bp_ctr_t CTR_WNT = 2'b01;
   localparam bp_ctr_t CTR_WT  = 2'b10;
   localparam bp_ctr_t CTR_ST  = 2'b11;

   localparam bp_ctr_t BP_RESET_CTR = CTR_WNT;

   function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
      return taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                   : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
   endfunction

endpackage

// File: rtl/bp_table.sv
// bp_table: direct-mapped counter/BTB entries with one combinational lookup port and one training port
module bp_table
   import bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   localparam int IDX_W = $clog2(ENTRIES),
   localparam int TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_taken,
   output logic [31:0]      rd_target,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             wr_taken,
   input  logic [31:0]      wr_target
);

   logic             valid_q  [ENTRIES];
   bp_ctr_t          ctr_q    [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic             wr_hit;

   assign rd_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && ctr_q[rd_idx][1];
   assign rd_target = target_q[rd_idx];
   assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   // valid/counter state: cleared on reset, trained on hits, allocated on taken misses
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= BP_RESET_CTR;
         end
      end else if (wr_en) begin
         if (wr_hit) ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
         else if (wr_taken) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= CTR_WT;
         end
      end
   end

   // tag/target payload: only meaningful behind a valid bit, so never reset; a taken hit rewrites the same tag
   always_ff @(posedge clk) begin
      if (wr_en && wr_taken) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side direction/target prediction, EX-side training and registered mispredict flush
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   localparam int IDX_W = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic        ex_branch,
   input  logic        ex_stall,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   logic [31:0] hit_target;
   logic        resolve;
   logic        mispredict;

   bp_table #(.ENTRIES(ENTRIES)) u_table (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (if_pc[IDX_W+1:2]),
      .rd_tag    (if_pc[31:IDX_W+2]),
      .rd_taken  (pred_taken),
      .rd_target (hit_target),
      .wr_en     (resolve),
      .wr_idx    (ex_pc[IDX_W+1:2]),
      .wr_tag    (ex_pc[31:IDX_W+2]),
      .wr_taken  (ex_taken),
      .wr_target (ex_target)
   );

   // while flush is high the EX instruction is wrong-path, so it neither trains nor flushes
   assign resolve     = ex_valid && ex_branch && !ex_stall && !flush;
   assign mispredict  = resolve && ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
   assign pred_target = pred_taken ? hit_target : if_pc + 32'd4;

   // one-cycle flush pulse with corrected PC, plus resolve/mispredict statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         flush            <= 1'b0;
         redirect_pc      <= '0;
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         flush <= mispredict;
         if (mispredict) redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
         if (resolve) stat_branches <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized checks of branch_predictor against a behavioural table model
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
   logic        ex_valid, ex_branch, ex_stall, ex_taken, ex_pred_taken;
   logic        pred_taken, flush;
   logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispredicts;

   int n_checks = 0;
   int n_fail   = 0;

   bit          m_valid [64];
   bit [29:0]   m_line  [64];
   int          m_ctr   [64];
   bit [31:0]   m_tgt   [64];
   bit          m_flush;
   bit [31:0]   m_redir, m_br, m_mis;

   branch_predictor #(.ENTRIES(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_branch        (ex_branch),
      .ex_stall         (ex_stall),
      .ex_pc            (ex_pc),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   function automatic int idx_of(input bit [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic bit m_pt(input bit [31:0] pc);
      int i = idx_of(pc);
      return m_valid[i] && (m_line[i] == pc[31:2]) && (m_ctr[i] >= 2);
   endfunction

   function automatic bit [31:0] m_ptg(input bit [31:0] pc);
      return m_pt(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit v, input bit b, input bit s, input bit [31:0] epc,
                             input bit tk, input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
      bit res, mis;
      int i;
      if (r) begin
         for (int k = 0; k < 64; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = 1;
         end
         m_flush = 1'b0;
         m_redir = '0;
         m_br    = '0;
         m_mis   = '0;
         return;
      end
      res = v && b && !s && !m_flush;
      mis = res && ((tk != ptk) || (tk && (tgt != ptgt)));
      i   = idx_of(epc);
      if (res) begin
         m_br++;
         if (m_valid[i] && (m_line[i] == epc[31:2])) begin
            m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
            if (tk) m_tgt[i] = tgt;
         end else if (tk) begin
            m_valid[i] = 1'b1;
            m_line[i]  = epc[31:2];
            m_ctr[i]   = 2;
            m_tgt[i]   = tgt;
         end
      end
      if (mis) begin
         m_mis++;
         m_redir = tk ? tgt : epc + 32'd4;
      end
      m_flush = mis;
   endtask

   task automatic step(input string tag, input bit r, input bit [31:0] ipc, input bit v, input bit b, input bit s,
                       input bit [31:0] epc, input bit tk, input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt,
                       input bit cp);
      rst = r; if_pc = ipc; ex_valid = v; ex_branch = b; ex_stall = s;
      ex_pc = epc; ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
      #1;
      if (cp) begin
         chk({tag, ":pred_taken"}, 32'(pred_taken), 32'(m_pt(ipc)));
         chk({tag, ":pred_target"}, pred_target, m_ptg(ipc));
      end
      model_edge(r, v, b, s, epc, tk, tgt, ptk, ptgt);
      @(posedge clk);
      #1;
      chk({tag, ":flush"}, 32'(flush), 32'(m_flush));
      if (m_flush || r) chk({tag, ":redirect_pc"}, redirect_pc, m_redir);
      chk({tag, ":stat_branches"}, stat_branches, m_br);
      chk({tag, ":stat_mispredicts"}, stat_mispredicts, m_mis);
      @(negedge clk);
   endtask

   task automatic idle(input string tag, input bit [31:0] ipc);
      step(tag, 1'b0, ipc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic res(input string tag, input bit [31:0] ipc, input bit [31:0] epc, input bit tk, input bit [31:0] tgt);
      step(tag, 1'b0, ipc, 1'b1, 1'b1, 1'b0, epc, tk, tgt, m_pt(epc), m_ptg(epc), 1'b1);
   endtask

   initial begin
      bit [31:0] epc, ipc, tgt, ptgt;
      bit ptk;
      rst = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_branch = 1'b0; ex_stall = 1'b0;
      ex_pc = '0; ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
      @(negedge clk);
      step("rst0", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step("rst1", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle("post_rst", 32'h100);
      chk("post_rst_target", pred_target, 32'h104);

      res("first_taken", 32'h100, 32'h100, 1'b1, 32'h80);
      chk("first_taken_redirect", redirect_pc, 32'h80);
      idle("lookup_trained", 32'h100);
      chk("lookup_trained_target", pred_target, 32'h80);

      res("sat1", 32'h104, 32'h100, 1'b1, 32'h80);
      res("sat2", 32'h104, 32'h100, 1'b1, 32'h80);
      res("sat3", 32'h104, 32'h100, 1'b1, 32'h80);
      res("nt1", 32'h100, 32'h100, 1'b0, 32'h80);
      chk("nt1_redirect", redirect_pc, 32'h104);
      idle("nt1_gap", 32'h100);
      res("nt2", 32'h100, 32'h100, 1'b0, 32'h80);
      idle("nt2_gap", 32'h100);
      idle("nt_lookup", 32'h100);

      res("alias_a", 32'h0, 32'h100, 1'b1, 32'h80);
      idle("alias_gap_a", 32'h0);
      res("alias_b", 32'h0, 32'h200, 1'b1, 32'h300);
      idle("alias_gap_b", 32'h0);
      idle("alias_look100", 32'h100);
      chk("alias_miss_target", pred_target, 32'h104);
      idle("alias_look200", 32'h200);
      chk("alias_hit_target", pred_target, 32'h300);

      res("wt_train", 32'h0, 32'h100, 1'b1, 32'h80);
      idle("wt_gap", 32'h100);
      step("wt_wrong", 1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1);
      chk("wt_redirect", redirect_pc, 32'h90);
      step("wt_shadow", 1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h90, 1'b1);
      idle("wt_lookup", 32'h100);
      chk("wt_new_target", pred_target, 32'h90);

      step("stall", 1'b0, 32'h400, 1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h404, 1'b1);
      step("unstall", 1'b0, 32'h400, 1'b1, 1'b1, 1'b0, 32'h400, 1'b1, 32'h500, 1'b0, 32'h404, 1'b1);
      step("rst_in_flush", 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle("after_rst_lookup", 32'h400);

      for (int n = 0; n < 600; n++) begin
         epc  = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         ipc  = ($urandom_range(0, 1) == 0) ? epc : ((32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2));
         tgt  = 32'($urandom_range(0, 3)) << 4;
         ptk  = m_pt(epc);
         ptgt = m_ptg(epc);
         if ($urandom_range(0, 4) == 0) begin
            ptk  = 1'($urandom_range(0, 1));
            ptgt = 32'($urandom_range(0, 3)) << 4;
         end
         step("rand", $urandom_range(0, 99) == 0, ipc, $urandom_range(0, 6) != 0, $urandom_range(0, 6) != 0,
              $urandom_range(0, 4) == 0, epc, 1'($urandom_range(0, 1)), tgt, ptk, ptgt, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side consumer of the execute-stage branch compare result in the pipelined RV32 core.
- Holds a direct-mapped table of 2-bit saturating counters plus a branch target buffer, and predicts taken/target for the fetch PC.
- Trains on resolved conditional branches from EX (taken flag from the branch comparator, target from the ALU).
- On misprediction, raises a registered one-cycle flush with the corrected PC.

Parameters:
- ENTRIES, 64, number of table entries; power of two, range 4..1024.
- IDX_W, $clog2(ENTRIES), index width; derived, never overridden.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_pc  in  32  PC currently being fetched
- pred_taken  out  1  prediction for if_pc; combinational from table state
- pred_target  out  32  predicted next PC: BTB target if predicted taken, else if_pc+4
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  EX instruction is a conditional branch (B-type)
- ex_stall  in  1  EX is held this cycle; no update, no flush
- ex_pc  in  32  PC of the EX instruction
- ex_taken  in  1  resolved outcome from the branch comparator
- ex_target  in  32  resolved branch target (ex_pc + imm)
- ex_pred_taken  in  1  pred_taken piped down with the instruction
- ex_pred_target  in  32  pred_target piped down with the instruction
- flush  out  1  registered one-cycle mispredict pulse
- redirect_pc  out  32  corrected PC; valid while flush=1
- stat_branches  out  32  count of resolved conditional branches
- stat_mispredicts  out  32  count of mispredictions

Behaviour:
- Address split: idx = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, ctr[1:0], target[31:0].
- Lookup is zero-latency and combinational:
  - hit = valid[idx] & (tag match).
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4. The add is 32-bit and wraps.
- A resolve event is ex_valid & ex_branch & ~ex_stall & ~flush. While flush=1, the instruction in EX is wrong-path and is ignored.
- Update on a resolve event, at the next clk edge:
  - Hit and taken: ctr saturating increment (max 2'b11); target <= ex_target.
  - Hit and not taken: ctr saturating decrement (min 2'b00). Target and valid are unchanged.
  - Miss and taken: allocate the entry. valid=1, tag written, ctr=2'b10, target=ex_target. Any existing entry at that index is overwritten.
  - Miss and not taken: no table change.
- Mispredict condition on a resolve event: (ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target)).
- On a mispredict, at the next edge:
  - flush <= 1.
  - redirect_pc <= ex_taken ? ex_target : ex_pc+4.
- flush is exactly one cycle wide. It returns to 0 on the following edge unless a new mispredict occurs; the suppression rule above prevents back-to-back flushes.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value. There is no bypass.
- Statistics:
  - stat_branches increments on every resolve event.
  - stat_mispredicts increments on every mispredict.
  - Both are 32-bit and wrap at 2^32-1 -> 0.
- Reset (rst=1 at an edge):
  - All valid bits = 0 and all ctr = 2'b01.
  - flush = 0, redirect_pc = 0, both statistics counters = 0.
  - Tag and target arrays need not be cleared.
  - Reset mid-operation discards any pending flush.
  - pred_taken = 0 and pred_target = if_pc+4 from the first cycle after reset.
- ex_stall=1: no table, flush or statistics change. flush already high still drops after its one cycle.

Decomposition:
- Shared package bp_pkg:
  - typedef bp_ctr_t (2-bit) and constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - function ctr_next(ctr, taken) implementing saturation.
  - constant BP_RESET_CTR = CTR_WNT.
- One natural sub-module, bp_table: entry arrays with one combinational read port and one synchronous write port. branch_predictor holds the lookup/compare logic, flush register and statistics counters.

Test Plan (ENTRIES=64):
- Reset, then lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104; stat_branches=0, stat_mispredicts=0.
- Resolve ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> next cycle flush=1, redirect_pc=0x80, stat_mispredicts=1. Then lookup 0x100 -> pred_taken=1, pred_target=0x80 (ctr=10).
- Saturation: three more taken resolves at 0x100 (predicted correctly) -> ctr=11, no flush. Then two not-taken resolves -> ctr=01, pred_taken=0; the first of the two flushes with redirect_pc=0x104.
- Aliasing: train 0x100 taken, then resolve 0x200 (same idx 0, different tag) taken to 0x300 -> lookup 0x100 misses (pred_target=0x104); lookup 0x200 hits, pred_target=0x300.
- Wrong target: hit predicted taken to 0x80, ex_target=0x90, ex_taken=1 -> flush, redirect_pc=0x90, table target becomes 0x90. A resolve presented during the flush cycle -> ignored (no counter or stat change).
- ex_stall=1 with a mispredicting branch -> no flush and no update. The same branch with stall released -> flush next cycle. Asserting rst during the flush cycle -> flush=0 and the table is cleared.
